// File: rtl/sqrt_bcd_display.sv
// Purpose: captures the sqrt result on endop, converts it to 3-digit BCD by double-dabble, scans it onto a 3-digit 7-seg display.
// Latency: bcd and the done pulse appear 8 cycles after the capture edge; one result per 9 cycles at most.
// Backpressure: none; endop during a conversion is dropped and sets sticky overrun. Option: LEADING_ZERO_BLANK_EN.
module sqrt_bcd_display #(
  parameter int REFRESH_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        endop,
  input  logic [7:0]  sqrt,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [11:0] bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              shreg;
  logic [11:0]             scratch;
  logic [2:0]              count;
  logic [11:0]             adj;
  logic [19:0]             shifted;
  logic                    load, step, last;
  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic                    blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Double-dabble step: add 3 to each nibble >= 5, then shift {scratch,shreg} left by one.
  always_comb begin
    adj[3:0]   = (scratch[3:0]   >= 4'd5) ? scratch[3:0]   + 4'd3 : scratch[3:0];
    adj[7:4]   = (scratch[7:4]   >= 4'd5) ? scratch[7:4]   + 4'd3 : scratch[7:4];
    adj[11:8]  = (scratch[11:8]  >= 4'd5) ? scratch[11:8]  + 4'd3 : scratch[11:8];
    shifted    = {adj, shreg} << 1;
  end

  // Next-state logic: IDLE accepts endop, CONV runs exactly 8 steps.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (endop) begin
          load      = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (count == 3'd7) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Conversion datapath; bcd only changes on the final step so the display never sees partial sums.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg   <= 8'd0;
      scratch <= 12'd0;
      count   <= 3'd0;
      bcd     <= 12'h000;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        shreg   <= sqrt;
        scratch <= 12'd0;
        count   <= 3'd0;
      end else if (step) begin
        scratch <= shifted[19:8];
        shreg   <= shifted[7:0];
        count   <= count + 3'd1;
      end
      if (last) bcd <= shifted[19:8];
    end
  end

  // Sticky flag for results dropped because a conversion was in flight.
  always_ff @(posedge clock) begin
    if (reset)                      overrun <= 1'b0;
    else if (endop && state == CONV) overrun <= 1'b1;
  end

  assign busy = (state == CONV);

  // Free-running scan counter; its top two bits pick the digit slot.
  always_ff @(posedge clock) begin
    if (reset) scan_cnt <= '0;
    else       scan_cnt <= scan_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  end

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

  // Digit select, optional leading-zero blanking and segment decode.
  always_comb begin
    an    = 3'b111;
    digit = 4'hF;
    blank = 1'b0;
    case (sel)
      2'd0: begin an = 3'b110; digit = bcd[3:0];  end
      2'd1: begin an = 3'b101; digit = bcd[7:4];  end
      2'd2: begin an = 3'b011; digit = bcd[11:8]; end
      default: begin an = 3'b111; digit = 4'hF; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    blank = ((sel == 2'd2) && (bcd[11:8] == 4'd0)) ||
            ((sel == 2'd1) && (bcd[11:4] == 8'd0));
`else
    blank = 1'b0;
`endif
    seg = blank ? 7'b1111111 : seg7(digit);
  end

endmodule

// File: tb/tb_sqrt_bcd_display.sv
module tb_sqrt_bcd_display;

  logic        clock;
  logic        reset;
  logic        endop;
  logic [7:0]  sqrt;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [11:0] bcd;
  logic [2:0]  an;
  logic [6:0]  seg;

  int tests = 0;
  int fails = 0;
  int scnt  = 0;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] e;
  } vec_t;

  vec_t vecs[12];

  sqrt_bcd_display #(.REFRESH_BITS(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .endop   (endop),
    .sqrt    (sqrt),
    .busy    (busy),
    .done    (done),
    .overrun (overrun),
    .bcd     (bcd),
    .an      (an),
    .seg     (seg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  // scnt models the DUT scan counter (cleared by any edge with reset high).
  task automatic tick();
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    scnt = r ? 0 : scnt + 1;
  endtask

  function automatic logic [6:0] exp_seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk_disp(input logic [11:0] b, input string nm);
    int s;
    logic [2:0] ea;
    logic [6:0] es;
    s = (scnt >> 2) & 3;
    case (s)
      0: begin ea = 3'b110; es = exp_seg7(b[3:0]); end
      1: begin
        ea = 3'b101; es = exp_seg7(b[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (b[11:4] == 8'd0) es = 7'b1111111;
`endif
      end
      2: begin
        ea = 3'b011; es = exp_seg7(b[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
        if (b[11:8] == 4'd0) es = 7'b1111111;
`endif
      end
      default: begin ea = 3'b111; es = 7'b1111111; end
    endcase
    chk($sformatf("%s an slot%0d", nm, s), {29'd0, an}, {29'd0, ea});
    chk($sformatf("%s seg slot%0d", nm, s), {25'd0, seg}, {25'd0, es});
  endtask

  task automatic scan_all(input logic [11:0] b, input string nm);
    for (int i = 0; i < 16; i++) begin
      chk_disp(b, nm);
      tick();
    end
  endtask

  task automatic run_conv(input logic [7:0] v, input logic [11:0] e, input string nm);
    int lat;
    int bcnt;
    endop = 1'b1;
    sqrt  = v;
    tick();
    endop = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, 8);
    chk({nm, " busy cycles"}, bcnt, 8);
    chk({nm, " bcd"}, {20'd0, bcd}, {20'd0, e});
    chk({nm, " busy at done"}, {31'd0, busy}, 0);
    tick();
    chk({nm, " done width"}, {31'd0, done}, 0);
  endtask

  initial begin
    int k;
    logic saw_done;

    vecs[0]  = '{8'd0,   12'h000};
    vecs[1]  = '{8'd2,   12'h002};
    vecs[2]  = '{8'd9,   12'h009};
    vecs[3]  = '{8'd10,  12'h010};
    vecs[4]  = '{8'd37,  12'h037};
    vecs[5]  = '{8'd99,  12'h099};
    vecs[6]  = '{8'd100, 12'h100};
    vecs[7]  = '{8'd128, 12'h128};
    vecs[8]  = '{8'd199, 12'h199};
    vecs[9]  = '{8'd200, 12'h200};
    vecs[10] = '{8'd254, 12'h254};
    vecs[11] = '{8'd255, 12'h255};

    reset = 1'b1;
    endop = 1'b0;
    sqrt  = 8'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and first scan slots.
    chk("reset bcd", {20'd0, bcd}, 0);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset overrun", {31'd0, overrun}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("reset an digit0", {29'd0, an}, {29'd0, 3'b110});
      chk("reset seg digit0", {25'd0, seg}, {25'd0, 7'b1000000});
      tick();
    end
    chk("reset an digit1", {29'd0, an}, {29'd0, 3'b101});

    // Table of conversions.
    for (int i = 0; i < 12; i++)
      run_conv(vecs[i].v, vecs[i].e, $sformatf("conv%0d", vecs[i].v));
    chk("table overrun", {31'd0, overrun}, 0);

    // Back-to-back: second endop in the done cycle.
    endop = 1'b1;
    sqrt  = 8'd255;
    tick();
    endop = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("b2b first done", {31'd0, done}, 1);
    chk("b2b first bcd", {20'd0, bcd}, 12'h255);
    endop = 1'b1;
    sqrt  = 8'd100;
    tick();
    endop = 1'b0;
    chk("b2b second busy", {31'd0, busy}, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("b2b second done", {31'd0, done}, 1);
    chk("b2b second bcd", {20'd0, bcd}, 12'h100);
    chk("b2b overrun", {31'd0, overrun}, 0);
    tick();
    scan_all(12'h100, "scan100");

    // Overrun: endop 3 cycles after capture is dropped.
    endop = 1'b1;
    sqrt  = 8'd37;
    tick();
    endop = 1'b0;
    tick();
    tick();
    endop = 1'b1;
    sqrt  = 8'd9;
    tick();
    endop = 1'b0;
    chk("ovr flag set", {31'd0, overrun}, 1);
    k = 3;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk("ovr latency", k, 8);
    chk("ovr bcd", {20'd0, bcd}, 12'h037);
    for (int i = 0; i < 12; i++) tick();
    chk("ovr sticky", {31'd0, overrun}, 1);
    chk("ovr no restart", {31'd0, busy}, 0);

    // Reset 4 cycles into converting 200.
    endop = 1'b1;
    sqrt  = 8'd200;
    tick();
    endop = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort bcd", {20'd0, bcd}, 0);
    chk("abort overrun", {31'd0, overrun}, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("abort no done", {31'd0, saw_done}, 0);
    chk("abort bcd held", {20'd0, bcd}, 0);
    run_conv(8'd5, 12'h005, "after abort");
    scan_all(12'h005, "scan005");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sqrt_bcd_display.md
Name: sqrt_bcd_display

Overview:
- Downstream consumer of the sqrt unit: samples its 8-bit result on the `endop` pulse.
- Converts the result to 3-digit BCD with an iterative shift-add-3 (double-dabble) sequencer.
- Drives a time-multiplexed 3-digit 7-segment display with the last completed result.
- Sits between the sqrt core and board display pins.

Parameters:
- REFRESH_BITS, 16, width of free-running scan counter; top 2 bits select digit slot.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- endop  input  1  sqrt-done strobe; sqrt valid in same cycle
- sqrt  input  8  unsigned root, 0..255
- busy  output  1  high while conversion in progress
- done  output  1  one-cycle pulse when bcd updated
- overrun  output  1  sticky: endop arrived while busy
- bcd  output  12  last result, {hundreds,tens,ones} nibbles
- an  output  3  digit enables, active-low, one-hot; an[0]=ones
- seg  output  7  segments active-low, order {g,f,e,d,c,b,a}

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; busy=0, done=0, overrun=0, bcd=12'h000.
  - Scan counter cleared; an=3'b110, seg=7'b1000000 (digit 0).
  - Reset mid-conversion aborts it; bcd stays 000.
- FSM, two states:
  - IDLE: endop=1 at edge E0 -> capture sqrt into 8-bit shift reg; clear 12-bit scratch; step count=0; go CONV; busy=1 from E0.
  - CONV: each edge:
    - Add 3 to every scratch nibble >=5 (combinational).
    - Shift {scratch,shreg} left 1.
    - Increment count.
  - On 8th CONV edge (E8): load bcd with final scratch; done=1 for exactly the following cycle; busy=0; go IDLE.
- Latency: done and new bcd visible 8 cycles after the capture edge.
- Max throughput: one result per 9 cycles. endop in the done cycle is accepted (state is IDLE).
- endop while CONV:
  - Ignored; the conversion in flight completes with the original value.
  - overrun set; cleared only by reset.
- bcd holds its value between conversions. Nibbles are always 0..9; hundreds nibble <=2.
- Display scan:
  - Counter increments every cycle and wraps.
  - sel = counter[REFRESH_BITS-1 -: 2].
  - sel 0/1/2 -> ones/tens/hundreds, an=110/101/011.
  - sel 3 -> an=111, seg=7'b1111111 (blank slot).
- Segment decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Other codes: all off.
- Display reads the bcd register only, never scratch; no mid-conversion glitches.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit: seg=1111111 when its nibble is 0.
  - Tens digit: blanked when hundreds and tens are both 0.
  - Ones digit: never blanked. an still scans normally.
- Not defined: all three digits always shown, including leading zeros.

Test Plan:
- Reset held 2 cycles, REFRESH_BITS=4 -> bcd=000, busy/done/overrun=0; an=110, seg=1000000 for 4 cycles, then an=101.
- sqrt=2, endop pulse -> busy high 8 cycles; done pulse 8 cycles after capture; bcd=12'h002; done 1 cycle wide.
- sqrt=255 then sqrt=100 back-to-back at minimum spacing (second endop in done cycle) -> bcd=12'h255, then 12'h100 nine cycles later; overrun=0.
- sqrt=37 captured, second endop 3 cycles later with sqrt=9 -> bcd=12'h037; overrun=1 and remains 1 until reset.
- Reset asserted 4 cycles into converting 200 -> busy=0, bcd=000, no done pulse; next endop with 5 converts to 12'h005.
- bcd=12'h005, scan all slots: with LEADING_ZERO_BLANK_EN -> hundreds/tens seg=1111111, ones=0010010; without -> 1000000, 1000000, 0010010.
